// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter with its return-address stack.
package pc_pkg;
  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    PC_HOLD, PC_CLEAR, PC_RET, PC_CALL, PC_DBUS, PC_LOAD1, PC_LOAD2, PC_REL, PC_UP
  } pc_op_e;

  // Sign-extends the low ofs_w bits of ofs to MAX_W bits.
  function automatic logic [MAX_W-1:0] sext_ofs(input logic [MAX_W-1:0] ofs,
                                                input int unsigned     ofs_w);
    logic signed [MAX_W-1:0] t;
    t = signed'(ofs << (MAX_W - ofs_w));
    return unsigned'(t >>> (MAX_W - ofs_w));
  endfunction
endpackage

// File: rtl/pc_stack_unit_if.sv
// Controller-facing command/status bundle of the program counter unit.
interface pc_stack_unit_if import pc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int OFS_W = 8
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic             clear;
  logic [WIDTH-1:0] d_bus;
  logic             d_bus_en;
  logic [WIDTH-1:0] input1;
  logic             load1;
  logic [WIDTH-1:0] input2;
  logic             load2;
  logic [OFS_W-1:0] rel_ofs;
  logic             rel_en;
  logic             call_en;
  logic             ret_en;
  logic             up;
  logic [1:0]       step;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] ret_top;
  logic [SP_W-1:0]  sp;
  logic             stk_empty;
  logic             stk_full;
  logic             ovf;
  logic             unf;

  modport master (
    output clear, d_bus, d_bus_en, input1, load1, input2, load2,
           rel_ofs, rel_en, call_en, ret_en, up, step,
    input  pc_out, ret_top, sp, stk_empty, stk_full, ovf, unf
  );

  modport slave (
    input  clear, d_bus, d_bus_en, input1, load1, input2, load2,
           rel_ofs, rel_en, call_en, ret_en, up, step,
    output pc_out, ret_top, sp, stk_empty, stk_full, ovf, unf
  );
endinterface

// File: rtl/pc_ret_stack.sv
// Return-address LIFO: owns the stack pointer and the sticky overflow/underflow flags.
module pc_ret_stack import pc_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         full,
  output logic                         empty,
  output logic                         ovf,
  output logic                         unf
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic             ovf_q, unf_q;
  logic             do_push, do_pop;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SP_W'(DEPTH));
  assign do_push = rst_n & ~clear & push & ~full;
  assign do_pop  = rst_n & ~clear & pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (do_push)     sp_q <= sp_q + SP_W'(1);
      else if (do_pop) sp_q <= sp_q - SP_W'(1);
      if (push && full)  ovf_q <= 1'b1;
      if (pop && empty)  unf_q <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset; sp alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[IDX_W'(sp_q)] <= push_data;
  end

  assign top = empty ? '0 : mem[IDX_W'(sp_q - SP_W'(1))];
  assign sp  = sp_q;
  assign ovf = ovf_q;
  assign unf = unf_q;
endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with load/relative/increment sources and a hardware call/return stack.
module pc_stack_unit import pc_pkg::*; #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter int               OFS_W    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_stack_unit_if.slave  bus
);
  pc_op_e           op;
  logic [WIDTH-1:0] pc_q, step_ext, rel_ext, top;
  logic             full, empty;

  always_comb begin
    op = PC_HOLD;
    if      (bus.clear)    op = PC_CLEAR;
    else if (bus.ret_en)   op = PC_RET;
    else if (bus.call_en)  op = PC_CALL;
    else if (bus.d_bus_en) op = PC_DBUS;
    else if (bus.load1)    op = PC_LOAD1;
    else if (bus.load2)    op = PC_LOAD2;
    else if (bus.rel_en)   op = PC_REL;
    else if (bus.up)       op = PC_UP;
  end

  assign step_ext = WIDTH'(bus.step);
  assign rel_ext  = WIDTH'(sext_ofs(MAX_W'(bus.rel_ofs), OFS_W));

  pc_ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (op == PC_CLEAR),
    .push      (op == PC_CALL),
    .pop       (op == PC_RET),
    .push_data (pc_q + step_ext),
    .top       (top),
    .sp        (bus.sp),
    .full      (full),
    .empty     (empty),
    .ovf       (bus.ovf),
    .unf       (bus.unf)
  );

  // A rejected call/ret leaves the PC where it was so software can recover.
  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= RESET_PC;
    else begin
      case (op)
        PC_CLEAR: pc_q <= RESET_PC;
        PC_RET:   if (!empty) pc_q <= top;
        PC_CALL:  if (!full)  pc_q <= bus.input1;
        PC_DBUS:  pc_q <= bus.d_bus;
        PC_LOAD1: pc_q <= bus.input1;
        PC_LOAD2: pc_q <= bus.input2;
        PC_REL:   pc_q <= pc_q + rel_ext;
        PC_UP:    pc_q <= pc_q + step_ext;
        default:  pc_q <= pc_q;
      endcase
    end
  end

  assign bus.pc_out    = pc_q;
  assign bus.ret_top   = top;
  assign bus.stk_empty = empty;
  assign bus.stk_full  = full;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed vector table, hand sequences and random traffic vs a queue model.
module tb_pc_stack_unit;
  localparam int W = 8, D = 4, OW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_stack_unit_if #(.WIDTH(W), .DEPTH(D), .OFS_W(OW)) bus ();

  pc_stack_unit #(.WIDTH(W), .DEPTH(D), .OFS_W(OW), .RESET_PC(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit       clr, ret, call, dben, l1, l2, rel, up;
    bit [1:0] step;
    bit [7:0] dbus, in1, in2, ofs;
  } cmd_t;

  typedef struct {
    cmd_t c;
    int   pc, sp, top;
  } vec_t;

  int checks = 0, errors = 0;
  int m_pc;
  int m_stk[$];
  bit m_ovf, m_unf;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t nop();
    cmd_t c;
    c = '{default: 0};
    return c;
  endfunction
  function automatic cmd_t c_dbus(input bit [7:0] v);
    cmd_t c = nop(); c.dben = 1; c.dbus = v; return c;
  endfunction
  function automatic cmd_t c_load1(input bit [7:0] v);
    cmd_t c = nop(); c.l1 = 1; c.in1 = v; return c;
  endfunction
  function automatic cmd_t c_load2(input bit [7:0] v);
    cmd_t c = nop(); c.l2 = 1; c.in2 = v; return c;
  endfunction
  function automatic cmd_t c_rel(input bit [7:0] v);
    cmd_t c = nop(); c.rel = 1; c.ofs = v; return c;
  endfunction
  function automatic cmd_t c_up(input bit [1:0] s);
    cmd_t c = nop(); c.up = 1; c.step = s; return c;
  endfunction
  function automatic cmd_t c_call(input bit [7:0] tgt, input bit [1:0] s);
    cmd_t c = nop(); c.call = 1; c.in1 = tgt; c.step = s; return c;
  endfunction
  function automatic cmd_t c_ret();
    cmd_t c = nop(); c.ret = 1; return c;
  endfunction

  task automatic drive(input cmd_t c);
    bus.clear    = c.clr;
    bus.ret_en   = c.ret;
    bus.call_en  = c.call;
    bus.d_bus_en = c.dben;
    bus.load1    = c.l1;
    bus.load2    = c.l2;
    bus.rel_en   = c.rel;
    bus.up       = c.up;
    bus.step     = c.step;
    bus.d_bus    = c.dbus;
    bus.input1   = c.in1;
    bus.input2   = c.in2;
    bus.rel_ofs  = c.ofs;
  endtask

  // Reference: PC as an integer mod 256, return stack as a queue, first enabled source wins.
  task automatic model_apply(input cmd_t c, input bit rst);
    if (rst || c.clr) begin
      m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (c.ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else m_unf = 1;
    end else if (c.call) begin
      if (m_stk.size() < D) begin
        m_stk.push_back((m_pc + c.step) % 256);
        m_pc = c.in1;
      end else m_ovf = 1;
    end
    else if (c.dben) m_pc = c.dbus;
    else if (c.l1)   m_pc = c.in1;
    else if (c.l2)   m_pc = c.in2;
    else if (c.rel)  m_pc = (m_pc + int'($signed(c.ofs))) & 255;
    else if (c.up)   m_pc = (m_pc + c.step) % 256;
  endtask

  task automatic cycle(input cmd_t c);
    int top;
    drive(c);
    @(posedge clk);
    model_apply(c, !rst_n);
    #1;
    top = (m_stk.size() > 0) ? m_stk[$] : 0;
    check("pc_out",    int'(bus.pc_out),    m_pc);
    check("sp",        int'(bus.sp),        m_stk.size());
    check("ret_top",   int'(bus.ret_top),   top);
    check("stk_empty", int'(bus.stk_empty), int'(m_stk.size() == 0));
    check("stk_full",  int'(bus.stk_full),  int'(m_stk.size() == D));
    check("ovf",       int'(bus.ovf),       int'(m_ovf));
    check("unf",       int'(bus.unf),       int'(m_unf));
  endtask

  vec_t vt[$];

  initial begin
    cmd_t c;
    int exp_pop [4];
    exp_pop = '{8'h31, 8'h21, 8'h11, 8'h34};
    drive(nop());

    // reset state
    rst_n = 1'b0;
    cycle(nop());
    cycle(c_call(8'h77, 2'd1));
    check("rst_pc", int'(bus.pc_out), 0);
    check("rst_sp", int'(bus.sp), 0);
    check("rst_empty", int'(bus.stk_empty), 1);
    check("rst_top", int'(bus.ret_top), 0);
    rst_n = 1'b1;

    // counting with wrap
    for (int i = 0; i < 300; i++) begin
      cycle(c_up(2'd1));
      if (i == 254) check("cnt_255", int'(bus.pc_out), 255);
      if (i == 255) check("cnt_wrap", int'(bus.pc_out), 0);
    end
    check("cnt_end", int'(bus.pc_out), 44);

    // directed vector table
    vt.push_back('{c_dbus(8'h10),       8'h10, 0, 0});
    vt.push_back('{c_rel(8'hF0),        8'h00, 0, 0});
    vt.push_back('{c_rel(8'h7F),        8'h7F, 0, 0});
    vt.push_back('{c_load1(8'h20),      8'h20, 0, 0});
    vt.push_back('{c_call(8'h80, 2'd1), 8'h80, 1, 8'h21});
    vt.push_back('{c_ret(),             8'h21, 0, 0});
    vt.push_back('{c_load2(8'h55),      8'h55, 0, 0});
    vt.push_back('{c_up(2'd0),          8'h55, 0, 0});
    vt.push_back('{c_up(2'd3),          8'h58, 0, 0});
    c = c_load1(8'h44); c.l2 = 1; c.in2 = 8'h66; c.up = 1; c.step = 2'd1;
    vt.push_back('{c, 8'h44, 0, 0});
    c = c_rel(8'h02); c.up = 1; c.step = 2'd1;
    vt.push_back('{c, 8'h46, 0, 0});
    vt.push_back('{c_call(8'h90, 2'd2), 8'h90, 1, 8'h48});
    vt.push_back('{c_call(8'hA0, 2'd1), 8'hA0, 2, 8'h91});
    c = c_dbus(8'h99); c.clr = 1; c.ret = 1; c.up = 1; c.step = 2'd1;
    vt.push_back('{c, 8'h00, 0, 0});
    c = c_dbus(8'h33); c.l1 = 1; c.in1 = 8'h44; c.up = 1; c.step = 2'd1;
    vt.push_back('{c, 8'h33, 0, 0});
    foreach (vt[i]) begin
      cycle(vt[i].c);
      check($sformatf("vec%0d_pc", i),  int'(bus.pc_out),  vt[i].pc);
      check($sformatf("vec%0d_sp", i),  int'(bus.sp),      vt[i].sp);
      check($sformatf("vec%0d_top", i), int'(bus.ret_top), vt[i].top);
    end
    check("clr_ovf", int'(bus.ovf), 0);

    // fill to full, overflow, then drain to underflow
    for (int k = 1; k <= 5; k++) begin
      cycle(c_call(8'(k * 16), 2'd1));
      if (k == 4) check("full_after4", int'(bus.stk_full), 1);
    end
    check("ovf_pc_held", int'(bus.pc_out), 8'h40);
    check("ovf_set", int'(bus.ovf), 1);
    check("ovf_sp", int'(bus.sp), 4);
    for (int k = 0; k < 5; k++) begin
      cycle(c_ret());
      if (k < 4) check($sformatf("pop%0d", k), int'(bus.pc_out), exp_pop[k]);
    end
    check("unf_pc_held", int'(bus.pc_out), 8'h34);
    check("unf_set", int'(bus.unf), 1);
    cycle(c_up(2'd1));
    check("flags_no_block", int'(bus.pc_out), 8'h35);

    // reset in the middle of a call sequence
    for (int k = 0; k < 3; k++) cycle(c_call(8'h50, 2'd1));
    check("pre_rst_sp", int'(bus.sp), 3);
    check("pre_rst_ovf", int'(bus.ovf), 1);
    rst_n = 1'b0;
    cycle(c_call(8'h60, 2'd1));
    check("mid_rst_pc", int'(bus.pc_out), 0);
    check("mid_rst_sp", int'(bus.sp), 0);
    check("mid_rst_ovf", int'(bus.ovf), 0);
    rst_n = 1'b1;
    cycle(c_up(2'd2));
    check("post_rst_up", int'(bus.pc_out), 2);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      c.clr  = ($urandom_range(63) == 0);
      c.ret  = ($urandom_range(5) == 0);
      c.call = ($urandom_range(4) == 0);
      c.dben = ($urandom_range(7) == 0);
      c.l1   = ($urandom_range(7) == 0);
      c.l2   = ($urandom_range(7) == 0);
      c.rel  = ($urandom_range(3) == 0);
      c.up   = ($urandom_range(1) == 0);
      c.step = 2'($urandom_range(3));
      c.dbus = 8'($urandom);
      c.in1  = 8'($urandom);
      c.in2  = 8'($urandom);
      c.ofs  = 8'($urandom);
      rst_n  = ($urandom_range(127) != 0);
      cycle(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised next-generation program counter for the CPU datapath.
- Keeps every load/clear/increment source of the current PC. Adds a signed relative branch, a configurable increment step, and a hardware return-address stack for call/return.
- Sits between the controller, the data bus and the instruction-memory address port.
- pc_out addresses instruction memory directly.

Parameters:
- WIDTH, 8, PC and address width in bits.
- DEPTH, 4, number of return-stack entries (>=1).
- OFS_W, 8, width of the signed relative-branch offset (<= WIDTH).
- RESET_PC, 0, PC value after reset or clear.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- clear  in  1  synchronous soft clear.
- d_bus  in  WIDTH  data-bus value.
- d_bus_en  in  1  load PC from d_bus.
- input1  in  WIDTH  controller jump target.
- load1  in  1  load PC from input1.
- input2  in  WIDTH  adder/alternate target.
- load2  in  1  load PC from input2.
- rel_ofs  in  OFS_W  signed branch offset (two's complement).
- rel_en  in  1  PC <= PC + sign-extended rel_ofs.
- call_en  in  1  push PC+step, jump to input1.
- ret_en  in  1  pop the return stack into PC.
- up  in  1  PC <= PC + step.
- step  in  2  increment amount 0..3.
- pc_out  out  WIDTH  current PC (registered).
- ret_top  out  WIDTH  top-of-stack value; 0 when empty.
- sp  out  $clog2(DEPTH+1)  number of valid stack entries.
- stk_empty  out  1  sp==0.
- stk_full  out  1  sp==DEPTH.
- ovf  out  1  sticky: call attempted while full.
- unf  out  1  sticky: return attempted while empty.

Behaviour:
- Reset state (rst_n=0 at a clock edge):
  - pc_out=RESET_PC, sp=0, ovf=0, unf=0.
  - stk_empty=1, stk_full=0, ret_top=0.
  - Stack RAM contents are not reset.
- Strict priority, highest first; exactly one action per cycle:
  - rst_n low, then clear, ret_en, call_en, d_bus_en, load1, load2, rel_en, up, then hold.
- clear: same effect as reset on all state.
- ret_en:
  - sp>0: pc_out<=stack[sp-1]; sp<=sp-1.
  - sp==0: pc_out holds, sp holds, unf<=1.
- call_en:
  - sp<DEPTH: stack[sp]<=pc_out+step (mod 2^WIDTH); sp<=sp+1; pc_out<=input1.
  - sp==DEPTH: no push, pc_out holds, ovf<=1. The jump is suppressed so a recoverable state is kept.
- d_bus_en, load1, load2: pc_out<=respective input.
- rel_en: pc_out<=pc_out+sext(rel_ofs), wraps modulo 2^WIDTH.
- up: pc_out<=pc_out+zext(step), wraps modulo 2^WIDTH. step=0 with up=1 behaves as hold.
- Latency: one cycle from command to pc_out for every operation. All outputs are registered or decoded from registered state only.
- Flags:
  - ovf/unf stay set until reset or clear.
  - Flags do not block later operations.
- ret_top is combinational from registered stack/sp: stack[sp-1] when sp>0, else 0.
- Lower-priority requests in the same cycle as a higher one are dropped; no queuing.
- A rejected call or ret still consumes priority, so no lower-priority action occurs that cycle.
- Reset or clear arriving in the same cycle as any command overrides it completely.

Decomposition:
- Shared package pc_pkg:
  - enum pc_op_e {PC_HOLD, PC_CLEAR, PC_RET, PC_CALL, PC_DBUS, PC_LOAD1, PC_LOAD2, PC_REL, PC_UP}.
  - Function sext_ofs for the offset extension.
- pc_stack_unit decodes the priority into pc_op_e combinationally, then applies it in one registered process.
- One sub-module, pc_ret_stack (parameters WIDTH, DEPTH):
  - Inputs push, pop, push_data.
  - Outputs top, sp, full, empty, ovf, unf.
  - Owns the pointer and flags.

Test Plan:
1. Reset, then up=1, step=1 for 300 cycles (WIDTH=8) -> pc_out counts 0..255, wraps to 0, reaches 44.
2. pc_out=0x10, rel_en=1, rel_ofs=0xF0 (-16) -> pc_out=0x00 next cycle. Repeat with rel_ofs=0x7F -> 0x7F.
3. pc_out=0x20, step=1, call_en=1, input1=0x80 -> pc_out=0x80, sp=1, ret_top=0x21. Then ret_en=1 -> pc_out=0x21, sp=0, stk_empty=1.
4. DEPTH=4: five consecutive calls -> after the 4th, stk_full=1. The 5th leaves pc_out unchanged and sets ovf=1. Then 5 returns -> 4 pops in LIFO order, the 5th sets unf=1 with pc_out held.
5. Same cycle clear=1, ret_en=1, d_bus_en=1, up=1 with sp=2 -> pc_out=RESET_PC, sp=0, ovf=unf=0. Then d_bus_en=1, load1=1, up=1, d_bus=0x33, input1=0x44 -> pc_out=0x33.
6. rst_n=0 mid-call sequence (sp=3, ovf=1) -> next edge pc_out=0, sp=0, ovf=0. Releasing rst_n with up=1 gives pc_out=step on the following edge.
